// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, d, bo, ovf
  );
  modport slave (
    input  start, a, b,
    output busy, done, d, bo, ovf
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, d, bo
  );
  modport slave (
    input  start, a, b,
    output busy, done, d, bo
  );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN for the signed overflow output.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  logic             dbit;
  logic             brw_nxt;
  logic [WIDTH-1:0] full;
  logic             accept;

  assign dbit    = sa_q[0] ^ sb_q[0] ^ brw_q;
  assign brw_nxt = (~sa_q[0] & sb_q[0])
                 | (~(sa_q[0] ^ sb_q[0]) & brw_q);
  // The new bit enters at the MSB; after WIDTH steps bit 0 is the LSB.
  assign full    = {dbit, res_q};
  assign accept  = bus.start
                && (state_q == IDLE || state_q == DONE);

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        res_d = full[WIDTH-1:1];
        brw_d = brw_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = full;
          bo_d    = brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (am_q != bm_q) && (dbit != am_q);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          brw_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomised self-checking bench for serial_sub (WIDTH=4).
// Build with SERIAL_SUB_OVF_EN to also check the overflow flag.
module tb_serial_sub;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  serial_sub_if #(.WIDTH(W)) sif ();

  serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned difference, borrow, signed overflow.
  function automatic int ref_d(int a, int b);
    return (a - b + (1 << W)) & MASK;
  endfunction

  function automatic int ref_bo(int a, int b);
    return (a < b) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(int a, int b);
    int sa, sb, df;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    df = sa - sb;
    return (df > (1 << (W - 1)) - 1
         || df < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(sif.busy), 0);
    check({tag, "_done"}, 32'(sif.done), 0);
    check({tag, "_d"}, 32'(sif.d), 0);
    check({tag, "_bo"}, 32'(sif.bo), 0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(sif.ovf), 0);
`endif
  endtask

  // Present operands with start for one edge; leaves DUT in RUN cycle 1.
  task automatic launch(input int a, input int b);
    sif.start = 1'b1;
    sif.a = W'(a);
    sif.b = W'(b);
    tick();
    sif.start = 1'b0;
    sif.a = W'($urandom);
    sif.b = W'($urandom);
  endtask

  // Wait (bounded) for done; `rem` is the number of edges still expected.
  task automatic wait_done(input string tag, input int a,
                           input int b, input int rem);
    int cyc = 0;
    while (!sif.done && cyc < 4 * W) begin
      check({tag, "_busy_run"}, 32'(sif.busy), 1);
      tick();
      cyc++;
    end
    check({tag, "_done"}, 32'(sif.done), 1);
    check({tag, "_lat"}, 32'(cyc), 32'(rem));
    check({tag, "_busy_dn"}, 32'(sif.busy), 0);
    check({tag, "_d"}, 32'(sif.d), 32'(ref_d(a, b)));
    check({tag, "_bo"}, 32'(sif.bo), 32'(ref_bo(a, b)));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(sif.ovf), 32'(ref_ovf(a, b)));
`endif
  endtask

  task automatic after_done(input string tag, input int a,
                            input int b, input int idle);
    for (int i = 0; i < idle; i++) begin
      tick();
      check({tag, "_nodone"}, 32'(sif.done), 0);
      check({tag, "_hold"}, 32'(sif.d), 32'(ref_d(a, b)));
    end
  endtask

  initial begin
    int a, b, pa, pb, gap;
    logic pend;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.a = '0;
    sif.b = '0;
    tick();
    tick();
    check_reset_outs("reset");
    rst = 1'b0;

    // Directed cases.
    launch(9, 3);
    wait_done("t1", 9, 3, W);
    after_done("t1", 9, 3, 3);

    launch(3, 9);
    wait_done("t2a", 3, 9, W);
    after_done("t2a", 3, 9, 1);
    launch(15, 15);
    wait_done("t2b", 15, 15, W);
    after_done("t2b", 15, 15, 1);
    launch(0, 1);
    wait_done("t2c", 0, 1, W);
    after_done("t2c", 0, 1, 1);

    // start during RUN must be ignored.
    launch(5, 2);
    tick();
    sif.start = 1'b1;
    sif.a = 4'd1;
    sif.b = 4'd7;
    tick();
    sif.start = 1'b0;
    wait_done("t3", 5, 2, W - 2);
    after_done("t3", 5, 2, W + 2);

    // Back-to-back from DONE.
    launch(9, 3);
    wait_done("t4a", 9, 3, W);
    launch(8, 1);
    check("t4_busy", 32'(sif.busy), 1);
    wait_done("t4b", 8, 1, W);
    after_done("t4b", 8, 1, 1);

    // Reset mid-RUN.
    launch(12, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outs("t5");
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      check("t5_nodone", 32'(sif.done), 0);
    end
    launch(12, 4);
    wait_done("t5b", 12, 4, W);
    after_done("t5b", 12, 4, 1);

`ifdef SERIAL_SUB_OVF_EN
    launch(7, 15);
    wait_done("t6a", 7, 15, W);
    after_done("t6a", 7, 15, 1);
    launch(6, 2);
    wait_done("t6b", 6, 2, W);
    after_done("t6b", 6, 2, 1);
`endif

    // Random operations, gaps, stray starts and back-to-back chains.
    pend = 1'b0;
    pa = 0;
    pb = 0;
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(MASK, 0));
      b = int'($urandom_range(MASK, 0));
      if (!pend)
        launch(a, b);
      else begin
        a = pa;
        b = pb;
      end
      if ($urandom_range(1, 0) == 1) begin
        tick();
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        wait_done("rnd_stray", a, b, W - 2);
      end else
        wait_done("rnd", a, b, W);
      pend = 1'b0;
      if ($urandom_range(2, 0) == 0) begin
        pa = int'($urandom_range(MASK, 0));
        pb = int'($urandom_range(MASK, 0));
        launch(pa, pb);
        pend = 1'b1;
      end else begin
        gap = int'($urandom_range(3, 1));
        after_done("rnd", a, b, gap);
      end
    end
    if (pend)
      wait_done("rnd_last", pa, pb, W);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
